branch_target_buffer_2way: RTL and testbench

- Parametrised 2-way set-associative BTB with CTR_W-bit saturating direction counters and per-set LRU replacement.
- Fetch stage issues a lookup on btb_pc; the registered prediction returns one cycle later.
- Decode/execute stage issues updates on btb_new_pc with resolved direction and target.
- Drop-in successor to the direct-mapped BTB: same clock/reset and update port names, plus a lookup handshake, a hit output and configurable depth/counter width.

---
 rtl/branch_target_buffer_2way.sv | 167 ++++++++++++++++
 tb/tb_branch_target_buffer_2way.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer_2way.sv
// branch_target_buffer_2way: a 2-way set-associative branch target buffer.
// Each way has a saturating direction counter, and each set has one LRU bit.
// A lookup is registered: its prediction appears on the cycle after the request.
// An update is applied at the clock edge.
// Optional statistics counters are enabled with the macro BTB_STATS_EN.
//
// Handshake: the lookup path has no ready signal, so every btb_lookup_en is
// accepted. btb_lookup_valid is high for exactly the one cycle after the
// request. While btb_lookup_valid is low, btb_hit, btb_valid_prediction and
// btb_target are all 0.
module branch_target_buffer_2way #(
  parameter int SETS  = 16,
  parameter int CTR_W = 2,
  parameter int PC_W  = 32
) (
  input  logic            btb_clk,
  input  logic            btb_reset,
  input  logic            btb_lookup_en,
  input  logic [PC_W-1:0] btb_pc,
  input  logic            btb_write,
  input  logic [PC_W-1:0] btb_new_pc,
  input  logic            btb_branch_taken,
  input  logic [PC_W-1:0] btb_data,
  output logic            btb_lookup_valid,
  output logic            btb_hit,
  output logic            btb_valid_prediction,
  output logic [PC_W-1:0] btb_target
`ifdef BTB_STATS_EN
  ,
  output logic [15:0]     btb_stat_lookups,
  output logic [15:0]     btb_stat_hits
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int WT_I  = 1 << (CTR_W - 1);
  localparam int WNT_I = WT_I - 1;
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = WT_I[CTR_W-1:0];
  localparam logic [CTR_W-1:0] CTR_WNT = WNT_I[CTR_W-1:0];

  // Entry storage. Each array is indexed [set][way].
  logic [1:0]       vld_mem [SETS];
  logic [TAG_W-1:0] tag_mem [SETS][2];
  logic [PC_W-1:0]  tgt_mem [SETS][2];
  logic [CTR_W-1:0] ctr_mem [SETS][2];
  logic             lru_mem [SETS];  // names the way to evict

  // Address split for the lookup port and the update port.
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit0, l_hit1, l_hit, l_way;
  logic             u_hit0, u_hit1, u_hit, u_way;
  logic [CTR_W-1:0] u_ctr_next;
  logic             unused_pc_bits;

  assign l_idx = btb_pc[IDX_W+1:2];
  assign l_tag = btb_pc[PC_W-1:IDX_W+2];
  assign u_idx = btb_new_pc[IDX_W+1:2];
  assign u_tag = btb_new_pc[PC_W-1:IDX_W+2];
  // The low two PC bits never take part in indexing or tag comparison.
  assign unused_pc_bits = ^{btb_pc[1:0], btb_new_pc[1:0]};

  // Lookup tag compare. Allocation happens only on a miss, so at most one
  // way can match.
  always_comb begin
    l_hit0 = vld_mem[l_idx][0] && (tag_mem[l_idx][0] == l_tag);
    l_hit1 = vld_mem[l_idx][1] && (tag_mem[l_idx][1] == l_tag);
    l_hit  = l_hit0 || l_hit1;
    l_way  = l_hit1;
  end

  // Update tag compare, way choice and next counter value.
  // On a miss the victim is the first invalid way, otherwise the LRU way.
  always_comb begin
    u_hit0     = vld_mem[u_idx][0] && (tag_mem[u_idx][0] == u_tag);
    u_hit1     = vld_mem[u_idx][1] && (tag_mem[u_idx][1] == u_tag);
    u_hit      = u_hit0 || u_hit1;
    u_way      = 1'b0;
    u_ctr_next = '0;
    if (u_hit) begin
      u_way = u_hit1;
    end else if (!vld_mem[u_idx][0]) begin
      u_way = 1'b0;
    end else if (!vld_mem[u_idx][1]) begin
      u_way = 1'b1;
    end else begin
      u_way = lru_mem[u_idx];
    end
    if (u_hit) begin
      if (btb_branch_taken) begin
        u_ctr_next = (ctr_mem[u_idx][u_way] == CTR_MAX) ? CTR_MAX
                                                        : ctr_mem[u_idx][u_way] + 1'b1;
      end else begin
        u_ctr_next = (ctr_mem[u_idx][u_way] == '0) ? '0
                                                   : ctr_mem[u_idx][u_way] - 1'b1;
      end
    end else begin
      u_ctr_next = btb_branch_taken ? CTR_WT : CTR_WNT;
    end
  end

  // Registered lookup result. The lookup reads the state as it was before
  // any update applied at the same edge.
  always_ff @(posedge btb_clk) begin
    if (btb_reset) begin
      btb_lookup_valid     <= 1'b0;
      btb_hit              <= 1'b0;
      btb_valid_prediction <= 1'b0;
      btb_target           <= '0;
    end else begin
      btb_lookup_valid     <= btb_lookup_en;
      btb_hit              <= btb_lookup_en && l_hit;
      btb_valid_prediction <= btb_lookup_en && l_hit && ctr_mem[l_idx][l_way][CTR_W-1];
      btb_target           <= (btb_lookup_en && l_hit) ? tgt_mem[l_idx][l_way] : '0;
    end
  end

  // Entry and LRU state. The update's LRU write comes after the lookup's LRU
  // write, so the update wins when both touch the same set.
  always_ff @(posedge btb_clk) begin
    if (btb_reset) begin
      for (int s = 0; s < SETS; s++) begin
        vld_mem[s] <= '0;
        lru_mem[s] <= 1'b0;
        for (int w = 0; w < 2; w++) begin
          tag_mem[s][w] <= '0;
          tgt_mem[s][w] <= '0;
          ctr_mem[s][w] <= '0;
        end
      end
    end else begin
      if (btb_lookup_en && l_hit) begin
        lru_mem[l_idx] <= ~l_way;
      end
      if (btb_write) begin
        vld_mem[u_idx][u_way] <= 1'b1;
        tag_mem[u_idx][u_way] <= u_tag;
        ctr_mem[u_idx][u_way] <= u_ctr_next;
        if (!u_hit || btb_branch_taken) begin
          tgt_mem[u_idx][u_way] <= btb_data;
        end
        lru_mem[u_idx] <= ~u_way;
      end
    end
  end

`ifdef BTB_STATS_EN
  // Saturating lookup and hit counters. They step on the same edge that
  // registers btb_lookup_valid and btb_hit.
  always_ff @(posedge btb_clk) begin
    if (btb_reset) begin
      btb_stat_lookups <= '0;
      btb_stat_hits    <= '0;
    end else begin
      if (btb_lookup_en && (btb_stat_lookups != 16'hFFFF)) begin
        btb_stat_lookups <= btb_stat_lookups + 16'd1;
      end
      if (btb_lookup_en && l_hit && (btb_stat_hits != 16'hFFFF)) begin
        btb_stat_hits <= btb_stat_hits + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer_2way.sv
// Testbench for branch_target_buffer_2way with SETS=16 and CTR_W=2.
// It applies a table of directed vectors, then runs hand-written reset
// sequences.
module tb_branch_target_buffer_2way;

  logic        btb_clk;
  logic        btb_reset;
  logic        btb_lookup_en;
  logic [31:0] btb_pc;
  logic        btb_write;
  logic [31:0] btb_new_pc;
  logic        btb_branch_taken;
  logic [31:0] btb_data;
  logic        btb_lookup_valid;
  logic        btb_hit;
  logic        btb_valid_prediction;
  logic [31:0] btb_target;
`ifdef BTB_STATS_EN
  logic [15:0] btb_stat_lookups;
  logic [15:0] btb_stat_hits;
`endif

  int checks = 0;
  int errors = 0;

  branch_target_buffer_2way #(.SETS(16), .CTR_W(2), .PC_W(32)) dut (
    .btb_clk              (btb_clk),
    .btb_reset            (btb_reset),
    .btb_lookup_en        (btb_lookup_en),
    .btb_pc               (btb_pc),
    .btb_write            (btb_write),
    .btb_new_pc           (btb_new_pc),
    .btb_branch_taken     (btb_branch_taken),
    .btb_data             (btb_data),
    .btb_lookup_valid     (btb_lookup_valid),
    .btb_hit              (btb_hit),
    .btb_valid_prediction (btb_valid_prediction),
    .btb_target           (btb_target)
`ifdef BTB_STATS_EN
    ,
    .btb_stat_lookups     (btb_stat_lookups),
    .btb_stat_hits        (btb_stat_hits)
`endif
  );

  // Clock generation.
  initial btb_clk = 1'b0;
  always #5 btb_clk = ~btb_clk;

  typedef struct {
    logic        le;
    logic [31:0] pc;
    logic        wr;
    logic [31:0] npc;
    logic        tk;
    logic [31:0] data;
    logic        lv;
    logic        hit;
    logic        pred;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[$];
  // Each entry packs the expected {lookup_valid, hit, valid_prediction, target}.
  logic [34:0] exp_q[$];

  task automatic add(input logic le, input logic [31:0] pc, input logic wr,
                     input logic [31:0] npc, input logic tk, input logic [31:0] data,
                     input logic lv, input logic hit, input logic pred,
                     input logic [31:0] tgt);
    vec_t v;
    v.le = le; v.pc = pc; v.wr = wr; v.npc = npc; v.tk = tk; v.data = data;
    v.lv = lv; v.hit = hit; v.pred = pred; v.tgt = tgt;
    vecs.push_back(v);
  endtask

  task automatic lk(input logic [31:0] pc, input logic hit, input logic pred,
                    input logic [31:0] tgt);
    add(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, hit, pred, tgt);
  endtask

  task automatic wr(input logic [31:0] npc, input logic tk, input logic [31:0] data);
    add(1'b0, 32'h0, 1'b1, npc, tk, data, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic le, input logic [31:0] pc, input logic w,
                       input logic [31:0] npc, input logic tk, input logic [31:0] data);
    btb_lookup_en    = le;
    btb_pc           = pc;
    btb_write        = w;
    btb_new_pc       = npc;
    btb_branch_taken = tk;
    btb_data         = data;
  endtask

  task automatic check_outs(input string tag, input logic lv, input logic hit,
                            input logic pred, input logic [31:0] tgt);
    chk({tag, " lookup_valid"}, {31'b0, btb_lookup_valid}, {31'b0, lv});
    chk({tag, " hit"}, {31'b0, btb_hit}, {31'b0, hit});
    chk({tag, " pred"}, {31'b0, btb_valid_prediction}, {31'b0, pred});
    chk({tag, " target"}, btb_target, tgt);
  endtask

  initial begin
    int exp_lookups;
    int exp_hits;
    logic [34:0] e;

    // Table of directed vectors. Each row gives one cycle of inputs and the
    // outputs expected just after that cycle's edge.
    lk(32'h4, 0, 0, 32'h0);
    wr(32'h4, 1, 32'hDEADBEEF);
    wr(32'h0, 0, 32'hFEEDBEEF);
    lk(32'h4, 1, 1, 32'hDEADBEEF);
    lk(32'h0, 1, 0, 32'hFEEDBEEF);
    // Counter walk on 0x4 starting at 2: N N N T T T N T.
    wr(32'h4, 0, 32'h11111111); lk(32'h4, 1, 0, 32'hDEADBEEF);
    wr(32'h4, 0, 32'h22222222); lk(32'h4, 1, 0, 32'hDEADBEEF);
    wr(32'h4, 0, 32'h33333333); lk(32'h4, 1, 0, 32'hDEADBEEF);
    wr(32'h4, 1, 32'h000000A0); lk(32'h4, 1, 0, 32'h000000A0);
    wr(32'h4, 1, 32'h000000B0); lk(32'h4, 1, 1, 32'h000000B0);
    wr(32'h4, 1, 32'h000000C0); lk(32'h4, 1, 1, 32'h000000C0);
    wr(32'h4, 0, 32'h000000D0); lk(32'h4, 1, 1, 32'h000000C0);
    wr(32'h4, 1, 32'h000000E0); lk(32'h4, 1, 1, 32'h000000E0);
    // Aliasing and LRU in set 1.
    wr(32'h1004, 1, 32'hDEADFEED);
    wr(32'h4, 1, 32'hDEADBEEF);
    lk(32'h4, 1, 1, 32'hDEADBEEF);
    lk(32'h1004, 1, 1, 32'hDEADFEED);
    lk(32'h4, 1, 1, 32'hDEADBEEF);
    wr(32'h2004, 1, 32'h20040000);
    lk(32'h1004, 0, 0, 32'h0);
    lk(32'h4, 1, 1, 32'hDEADBEEF);
    lk(32'h2004, 1, 1, 32'h20040000);
    // Same-cycle lookup and update of a new entry: the lookup sees the old state.
    add(1, 32'h8, 1, 32'h8, 1, 32'h00008888, 1, 0, 0, 32'h0);
    lk(32'h8, 1, 1, 32'h00008888);
    // Set 3: when a lookup and an update touch the same set in one cycle,
    // the update's MRU choice must win.
    wr(32'hC, 1, 32'h0000C0C0);
    wr(32'h100C, 1, 32'h0000100C);
    add(1, 32'hC, 1, 32'h100C, 1, 32'h0000100D, 1, 1, 1, 32'h0000C0C0);
    wr(32'h200C, 1, 32'h0000200C);
    lk(32'hC, 0, 0, 32'h0);
    lk(32'h100C, 1, 1, 32'h0000100D);
    lk(32'h200C, 1, 1, 32'h0000200C);

    // Reset, then check the reset state of all outputs.
    btb_reset = 1'b1;
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge btb_clk);
    #1;
    check_outs("reset", 0, 0, 0, 32'h0);
`ifdef BTB_STATS_EN
    chk("reset stat_lookups", {16'b0, btb_stat_lookups}, 32'd0);
    chk("reset stat_hits", {16'b0, btb_stat_hits}, 32'd0);
`endif
    @(negedge btb_clk);
    btb_reset = 1'b0;

    // Apply the table. The scoreboard queue holds the expected result of each row.
    exp_lookups = 0;
    exp_hits = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge btb_clk);
      drive(vecs[i].le, vecs[i].pc, vecs[i].wr, vecs[i].npc, vecs[i].tk, vecs[i].data);
      exp_q.push_back({vecs[i].lv, vecs[i].hit, vecs[i].pred, vecs[i].tgt});
      if (vecs[i].le) exp_lookups++;
      if (vecs[i].hit) exp_hits++;
      @(posedge btb_clk);
      #1;
      e = exp_q.pop_front();
      check_outs($sformatf("vec%0d", i), e[34], e[33], e[32], e[31:0]);
    end
    @(negedge btb_clk);
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0);
`ifdef BTB_STATS_EN
    chk("stat_lookups", {16'b0, btb_stat_lookups}, exp_lookups);
    chk("stat_hits", {16'b0, btb_stat_hits}, exp_hits);
`endif

    // Assert reset during a lookup and an update. The reset must win and the
    // update must be discarded.
    @(negedge btb_clk);
    btb_reset = 1'b1;
    drive(1, 32'h4, 1, 32'h30, 1, 32'h30303030);
    @(posedge btb_clk);
    #1;
    check_outs("midreset", 0, 0, 0, 32'h0);
`ifdef BTB_STATS_EN
    chk("midreset stat_lookups", {16'b0, btb_stat_lookups}, 32'd0);
    chk("midreset stat_hits", {16'b0, btb_stat_hits}, 32'd0);
`endif
    @(negedge btb_clk);
    btb_reset = 1'b0;
    drive(1, 32'h30, 0, 32'h0, 0, 32'h0);
    @(posedge btb_clk);
    #1;
    check_outs("post reset 0x30", 1, 0, 0, 32'h0);
    @(negedge btb_clk);
    drive(1, 32'h4, 0, 32'h0, 0, 32'h0);
    @(posedge btb_clk);
    #1;
    check_outs("post reset 0x4", 1, 0, 0, 32'h0);
    @(negedge btb_clk);
    drive(0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(posedge btb_clk);
    #1;
    check_outs("idle", 0, 0, 0, 32'h0);
`ifdef BTB_STATS_EN
    chk("post reset stat_lookups", {16'b0, btb_stat_lookups}, 32'd2);
    chk("post reset stat_hits", {16'b0, btb_stat_hits}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
